// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared types and constants for the VRAM arbiter slice
package vram_pkg;

    localparam int ADDR_W       = 17;
    localparam int FB_WORDS_DEF = 76800;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } state_e;

endpackage

// File: rtl/vram_wr_fifo.sv
// rtl/vram_wr_fifo.sv - synchronous writer queue with registered occupancy count
module vram_wr_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        o_full     = (count_q == CW'(DEPTH));
        o_empty    = (count_q == '0);
        o_pop_data = mem_q[rd_ptr_q];
        do_push    = i_push && !o_full;
        do_pop     = i_pop && !o_empty;
        wr_ptr_d   = wr_ptr_q + PW'(do_push);
        rd_ptr_d   = rd_ptr_q + PW'(do_pop);
        count_d    = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; occupancy alone defines validity.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= i_push_data;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port VRAM arbiter: display read > frame clear > queued writes
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int FB_WORDS   = FB_WORDS_DEF,
    parameter int DW         = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_pix_stb,
    input  logic              i_active,
    input  logic [ADDR_W-1:0] i_xy,
    input  logic              i_wr_valid,
    output logic              o_wr_ready,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DW-1:0]     i_wr_data,
    input  logic              i_clr_req,
    input  logic [DW-1:0]     i_clr_color,
    output logic              o_clr_busy,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic              o_ram_we,
    output logic [DW-1:0]     o_ram_wdata,
    input  logic [DW-1:0]     i_ram_rdata,
    output logic [DW-1:0]     o_pixel,
    output logic              o_pixel_valid
);

    localparam logic [ADDR_W-1:0] FB_LAST = ADDR_W'(FB_WORDS - 1);
    localparam int                EW      = ADDR_W + DW;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]     color_q, color_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic              rd_q, rd_d;
    logic              pix_valid_q, pix_valid_d;
    logic [DW-1:0]     pixel_q, pixel_d;

    logic              disp;
    logic              fifo_full, fifo_empty, fifo_pop, fifo_push;
    logic [EW-1:0]     fifo_head;
    logic [ADDR_W-1:0] head_addr;
    logic [DW-1:0]     head_data;

    assign disp      = i_pix_stb && i_active;
    assign fifo_push = i_wr_valid && o_wr_ready;
    assign head_addr = fifo_head[EW-1:DW];
    assign head_data = fifo_head[DW-1:0];

    vram_wr_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (fifo_push),
        .i_push_data ({i_wr_addr, i_wr_data}),
        .i_pop       (fifo_pop),
        .o_pop_data  (fifo_head),
        .o_full      (fifo_full),
        .o_empty     (fifo_empty)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            color_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_q        <= 1'b0;
            pix_valid_q <= 1'b0;
            pixel_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            color_q     <= color_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rd_q        <= rd_d;
            pix_valid_q <= pix_valid_d;
            pixel_q     <= pixel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        color_d = color_q;
        case (state_q)
            IDLE: begin
                if (i_clr_req) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                    color_d = i_clr_color;
                end
            end
            DRAIN: begin
                if (fifo_empty) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                // Counter advances only on cycles where the clear actually owns the port.
                if (!disp) begin
                    if (cnt_q == FB_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_ram_we    = 1'b0;
        o_ram_addr  = addr_q;
        o_ram_wdata = wdata_q;
        fifo_pop    = 1'b0;
        if (disp) begin
            o_ram_addr = i_xy;
        end else if (state_q == CLEAR) begin
            o_ram_we    = 1'b1;
            o_ram_addr  = cnt_q;
            o_ram_wdata = color_q;
        end else if (!fifo_empty) begin
            fifo_pop = 1'b1;
            if (head_addr <= FB_LAST) begin
                o_ram_we    = 1'b1;
                o_ram_addr  = head_addr;
                o_ram_wdata = head_data;
            end
        end
        addr_d        = o_ram_addr;
        wdata_d       = o_ram_wdata;
        rd_d          = disp;
        pix_valid_d   = rd_q;
        pixel_d       = rd_q ? i_ram_rdata : pixel_q;
        o_wr_ready    = !fifo_full && (state_q == IDLE);
        o_clr_busy    = (state_q != IDLE);
        o_pixel       = pixel_q;
        o_pixel_valid = pix_valid_q;
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - scoreboard bench for vram_arbiter
module tb_vram_arbiter;

    localparam int FBW = 76800;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb = 1'b0, active = 1'b0;
    logic [16:0] xy = '0;
    logic        wr_valid = 1'b0, wr_ready;
    logic [16:0] wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        clr_req = 1'b0, clr_busy;
    logic [7:0]  clr_color = '0;
    logic [16:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata, ram_rdata = '0;
    logic [7:0]  pixel;
    logic        pixel_valid;

    vram_arbiter #(.FB_WORDS(FBW), .DW(8), .FIFO_DEPTH(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_pix_stb(stb), .i_active(active), .i_xy(xy),
        .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_clr_req(clr_req), .i_clr_color(clr_color), .o_clr_busy(clr_busy),
        .o_ram_addr(ram_addr), .o_ram_we(ram_we), .o_ram_wdata(ram_wdata),
        .i_ram_rdata(ram_rdata), .o_pixel(pixel), .o_pixel_valid(pixel_valid)
    );

    always #5 clk = ~clk;

    // RAM model: every location reads back as its own low address byte.
    always @(posedge clk) ram_rdata <= ram_addr[7:0];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int a; int d; } wr_t;
    typedef struct { int c; int d; } px_t;
    wr_t exp_wr[$];
    px_t exp_px[$];

    int total = 0;
    int bad = 0;
    int n_wr = 0;
    int last_wr_cyc = 0;

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a write or a pixel.
    always @(negedge clk) begin
        if (rst_n) begin
            if (stb && active) begin
                chk("slot_we", int'(ram_we), 0);
                chk("slot_addr", int'(ram_addr), int'(xy));
            end
            if (ram_we) begin
                chk("wr_expected", int'(exp_wr.size() > 0), 1);
                if (exp_wr.size() > 0) begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    chk("wr_addr", int'(ram_addr), e.a);
                    chk("wr_data", int'(ram_wdata), e.d);
                end
                n_wr++;
                last_wr_cyc = cyc;
            end
            if (pixel_valid) begin
                chk("px_expected", int'(exp_px.size() > 0), 1);
                if (exp_px.size() > 0) begin
                    px_t p;
                    p = exp_px.pop_front();
                    chk("px_cycle", cyc, p.c);
                    chk("px_data", int'(pixel), p.d);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_slot(input bit s, input bit a, input int pos, input bit expect_px);
        stb = s;
        active = a;
        xy = 17'(pos);
        if (s && a && expect_px) exp_px.push_back('{cyc + 2, pos & 255});
    endtask

    task automatic push_wr(input int a, input int d);
        int  n = 0;
        bit  ok = 1'b1;
        wr_valid = 1'b1;
        wr_addr  = 17'(a);
        wr_data  = 8'(d);
        forever begin
            @(negedge clk);
            if (wr_ready) break;
            n++;
            if (n > 3000) begin
                ok = 1'b0;
                chk("wr_ready_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        if (ok && a < FBW) exp_wr.push_back('{a, d});
        #1;
        wr_valid = 1'b0;
    endtask

    task automatic pulse_clear(input int color, input int n_exp);
        tick();
        clr_color = 8'(color);
        clr_req = 1'b1;
        for (int i = 0; i < n_exp; i++) exp_wr.push_back('{i, color});
        tick();
        clr_req = 1'b0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_we", int'(ram_we), 0);
        chk("rst_addr", int'(ram_addr), 0);
        chk("rst_wdata", int'(ram_wdata), 0);
        chk("rst_pixel", int'(pixel), 0);
        chk("rst_pvalid", int'(pixel_valid), 0);
        chk("rst_busy", int'(clr_busy), 0);
    endtask

    task automatic release_reset();
        exp_wr.delete();
        exp_px.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("ready_after_rst", int'(wr_ready), 1);
        chk("busy_after_rst", int'(clr_busy), 0);
    endtask

    // Display strobes every cycle while nw writes are queued; they must land back-to-back afterwards.
    task automatic burst(input int nw, input int base_a, input int base_d, input int slots);
        int n0, free_cyc;
        n0 = n_wr;
        free_cyc = 0;
        fork
            begin
                for (int i = 0; i < slots; i++) begin
                    tick();
                    drive_slot(1'b1, 1'b1, $urandom_range(FBW - 1, 0), 1'b1);
                end
                tick();
                drive_slot(1'b0, 1'b0, 0, 1'b0);
                free_cyc = cyc;
            end
            begin
                for (int i = 0; i < nw; i++) push_wr(base_a + i, base_d + i);
                if (nw == 4) begin
                    @(negedge clk);
                    chk("ready_low_full", int'(wr_ready), 0);
                end
            end
        join
        repeat (nw + 4) tick();
        chk("burst_count", n_wr - n0, nw);
        chk("burst_last_cyc", last_wr_cyc, free_cyc + nw - 1);
    endtask

    initial begin
        int n0, guard;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;
        tick();
        chk("ready_init", int'(wr_ready), 1);

        // Scan-out: slot every second cycle, xy 0..3.
        for (int k = 0; k < 4; k++) begin
            tick();
            drive_slot(1'b1, 1'b1, k, 1'b1);
            tick();
            drive_slot(1'b0, 1'b1, k, 1'b0);
        end
        repeat (5) tick();
        chk("px_drained", exp_px.size(), 0);

        burst(4, 10, 8'hA0, 12);
        burst(2, 40, 8'h30, 8);

        // Out-of-range write is consumed silently; the next write still lands.
        n0 = n_wr;
        push_wr(80000, 8'h77);
        push_wr(20, 8'h21);
        repeat (6) tick();
        chk("oor_count", n_wr - n0, 1);

        // Randomised traffic.
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    tick();
                    drive_slot(($urandom % 3) == 0, ($urandom % 4) != 0,
                               $urandom_range(FBW - 1, 0), 1'b1);
                end
                tick();
                drive_slot(1'b0, 1'b0, 0, 1'b0);
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    push_wr($urandom_range(82000, 0), $urandom_range(255, 0));
                    repeat ($urandom_range(3, 0)) tick();
                end
            end
        join
        repeat (10) tick();
        chk("rand_wr_left", exp_wr.size(), 0);
        chk("rand_px_left", exp_px.size(), 0);

        // Full-frame clear with two writes already queued.
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    tick();
                    drive_slot(1'b1, 1'b1, i, 1'b1);
                    if (i == 4) begin
                        clr_color = 8'h55;
                        clr_req = 1'b1;
                        for (int j = 0; j < FBW; j++) exp_wr.push_back('{j, 8'h55});
                    end else begin
                        clr_req = 1'b0;
                    end
                    if (i == 5) begin
                        @(negedge clk);
                        chk("busy_rise", int'(clr_busy), 1);
                        chk("ready_drain", int'(wr_ready), 0);
                    end
                end
                tick();
                drive_slot(1'b0, 1'b0, 0, 1'b0);
            end
            begin
                push_wr(100, 8'h11);
                push_wr(101, 8'h12);
            end
        join
        guard = 0;
        forever begin
            @(negedge clk);
            if (!clr_busy) break;
            guard++;
            if (guard > 80000) begin
                chk("clear_timeout", 0, 1);
                break;
            end
        end
        chk("busy_fall_cyc", cyc, last_wr_cyc + 1);
        chk("clear_left", exp_wr.size(), 0);

        // Reset flushes a read still in flight.
        tick();
        drive_slot(1'b1, 1'b1, 5, 1'b0);
        tick();
        drive_slot(1'b0, 1'b0, 0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("flush_pvalid", int'(pixel_valid), 0);
        release_reset();
        repeat (4) tick();

        // Reset in the middle of a clear, then the clear restarts from address 0.
        pulse_clear(8'h3C, 1001);
        guard = 0;
        forever begin
            @(negedge clk);
            if (ram_we && ram_addr == 17'd1000) break;
            guard++;
            if (guard > 3000) begin
                chk("clear1000_timeout", 0, 1);
                break;
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        release_reset();
        pulse_clear(8'h3C, 20);
        guard = 0;
        forever begin
            @(negedge clk);
            #1;
            if (exp_wr.size() == 0) break;
            guard++;
            if (guard > 200) begin
                chk("restart_timeout", 0, 1);
                break;
            end
        end
        chk("restart_busy", int'(clr_busy), 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        release_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter FB_WORDS, default 76800, framebuffer depth in words (320x240).
REQ-002 Parameter DW, default 8, pixel/data width.
REQ-003 Parameter FIFO_DEPTH, default 4, writer queue depth (power of two).
REQ-004 i_clk  in  1  single clock; all logic on rising edge.
REQ-005 i_rst_n  in  1  asynchronous, active-low reset.
REQ-006 i_pix_stb  in  1  pixel strobe from timing generator.
REQ-007 i_active  in  1  high during active pixel drawing.
REQ-008 i_xy  in  17  current pixel number.
REQ-009 i_wr_valid / o_wr_ready  in/out  1  writer handshake.
REQ-010 i_wr_addr  in  17  writer address; i_wr_data  in  DW  writer data.
REQ-011 i_clr_req  in  1  one-cycle pulse requesting a full-frame clear; i_clr_color  in  DW  fill value.
REQ-012 o_clr_busy  out  1  high from clear acceptance until last clear write.
REQ-013 o_ram_addr  out  17; o_ram_we  out  1; o_ram_wdata  out  DW  single-port VRAM command.
REQ-014 i_ram_rdata  in  DW  VRAM read data, valid exactly one cycle after the read command.
REQ-015 o_pixel  out  DW; o_pixel_valid  out  1  scan-out pixel and qualifier.

Function
REQ-016 Exactly one VRAM access per cycle; priority: display read > clear write > FIFO write.
REQ-017 Display slot = i_pix_stb && i_active: o_ram_addr=i_xy, o_ram_we=0.
REQ-018 o_pixel/o_pixel_valid registered from i_ram_rdata two cycles after display slot (1 RAM + 1 output register); o_pixel_valid high one cycle per slot, else 0; o_pixel holds last value.
REQ-019 Writer handshake: transfer when i_wr_valid && o_wr_ready; o_wr_ready = FIFO not full and state IDLE.
REQ-020 FIFO push and pop in same cycle when full: pop occurs, push blocked (o_wr_ready was 0); when empty, no bypass -- data reaches RAM no earlier than cycle after push.
REQ-021 FIFO write issued only in cycles with no display slot and state not CLEAR; o_ram_we=1 with popped addr/data.
REQ-022 Writes with address >= FB_WORDS are popped and discarded (o_ram_we=0).
REQ-023 States IDLE, DRAIN, CLEAR. IDLE--i_clr_req-->DRAIN (latch i_clr_color, counter=0, o_clr_busy=1).
REQ-024 DRAIN: o_wr_ready=0, FIFO drains normally; FIFO empty -->CLEAR (same cycle if already empty on entry next cycle).
REQ-025 CLEAR: each non-display cycle writes latched color to counter address, counter++; write at FB_WORDS-1 -->IDLE, o_clr_busy falls the cycle after.
REQ-026 i_clr_req while DRAIN/CLEAR ignored; counter never exceeds FB_WORDS-1.
REQ-027 When no access granted: o_ram_we=0, o_ram_addr holds previous value.

Reset
REQ-028 On i_rst_n low: state IDLE, FIFO empty, counter 0, o_ram_we=0, o_ram_addr=0, o_ram_wdata=0, o_pixel=0, o_pixel_valid=0, o_clr_busy=0; o_wr_ready=1 after release.
REQ-029 Reset mid-clear aborts clear; partially cleared memory not restored; FIFO contents lost.
REQ-030 Display read pipeline flushed; no o_pixel_valid for slots issued before reset.

Structure
REQ-031 Shared package vram_pkg holds state enum (IDLE, DRAIN, CLEAR), address width 17, FB_WORDS default.
REQ-032 FIFO is sub-module vram_wr_fifo (sync, registered count, full/empty flags).

Verification
REQ-033 Strobe every 2nd cycle, active, i_xy=0..3, RAM model returning addr[7:0] -> o_pixel 0,1,2,3, each 2 cycles after its slot.
REQ-034 Writer pushes 4 entries (addr 10..13, data 0xA0..0xA3) during blanking -> 4 consecutive writes, o_wr_ready low while full.
REQ-035 Continuous display strobes every cycle with 2 queued writes -> zero writes while strobing, both issued first idle cycles in order.
REQ-036 i_clr_req color 0x55 with 2 FIFO entries -> FIFO writes first, then 76800 writes of 0x55 to 0..76799, o_clr_busy falls after last.
REQ-037 Write to addr 80000 -> popped, o_ram_we stays 0.
REQ-038 i_rst_n low at clear address 1000 -> all outputs per REQ-028, state IDLE, later clear restarts at 0.
